// File: rtl/perf_event_monitor.sv
// ============================================================================
//  Module   : perf_event_monitor
//  Purpose  : Multi-channel event/hit/miss monitor with saturating counters,
//             windowed miss tracking and a registered read port.
//             Optional sticky window-miss alarm: define PERF_MON_ALARM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_event_monitor #(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 32,
    parameter  int WINDOW    = 64,
    parameter  int ALARM_THR = 16,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int WIN_W     = $clog2(WINDOW + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [NUM_CH-1:0] i_evt,
    input  logic [NUM_CH-1:0] i_hit,
    input  logic              i_rd_vld,
    input  logic [CH_W-1:0]   i_rd_ch,
    input  logic [1:0]        i_rd_sel,
    output logic              o_rd_vld,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic [NUM_CH-1:0] o_win_done,
    output logic [NUM_CH-1:0] o_alarm
);

    localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WINDOW - 1);

    // Flattened per-channel state for the read mux
    logic [NUM_CH-1:0][CNT_W-1:0] w_evt_all;
    logic [NUM_CH-1:0][CNT_W-1:0] w_hit_all;
    logic [NUM_CH-1:0][CNT_W-1:0] w_miss_all;
    logic [NUM_CH-1:0][WIN_W-1:0] w_last_all;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] r_evt_cnt;
        logic [CNT_W-1:0] r_hit_cnt;
        logic [CNT_W-1:0] r_miss_cnt;
        logic [WIN_W-1:0] r_win_cnt;
        logic [WIN_W-1:0] r_win_miss;
        logic [WIN_W-1:0] r_last_win_miss;
        logic             r_win_done;
        logic             w_qual;
        logic             w_miss;
        logic             w_close;
        logic [WIN_W-1:0] w_close_miss;

        assign w_qual       = i_en & i_evt[c];
        assign w_miss       = w_qual & ~i_hit[c];
        assign w_close      = w_qual && (r_win_cnt == c_win_last);
        assign w_close_miss = r_win_miss + WIN_W'(w_miss);

        always_ff @(posedge i_clk) begin
            if (i_rst || i_clr) begin
                r_evt_cnt       <= '0;
                r_hit_cnt       <= '0;
                r_miss_cnt      <= '0;
                r_win_cnt       <= '0;
                r_win_miss      <= '0;
                r_last_win_miss <= '0;
                r_win_done      <= 1'b0;
            end else begin
                r_win_done <= w_close;
                if (w_qual) begin
                    if (r_evt_cnt != '1)
                        r_evt_cnt <= r_evt_cnt + 1'b1;
                    if (i_hit[c]) begin
                        if (r_hit_cnt != '1)
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else if (r_miss_cnt != '1) begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                    // The closing event's own miss belongs to the closing window
                    if (w_close) begin
                        r_win_cnt       <= '0;
                        r_win_miss      <= '0;
                        r_last_win_miss <= w_close_miss;
                    end else begin
                        r_win_cnt  <= r_win_cnt + 1'b1;
                        r_win_miss <= w_close_miss;
                    end
                end
            end
        end

        assign w_evt_all[c]  = r_evt_cnt;
        assign w_hit_all[c]  = r_hit_cnt;
        assign w_miss_all[c] = r_miss_cnt;
        assign w_last_all[c] = r_last_win_miss;
        assign o_win_done[c] = r_win_done;

`ifdef PERF_MON_ALARM_EN
        logic r_alarm;

        always_ff @(posedge i_clk) begin
            if (i_rst || i_clr)
                r_alarm <= 1'b0;
            else if (w_close && (int'(w_close_miss) > ALARM_THR))
                r_alarm <= 1'b1;
        end

        assign o_alarm[c] = r_alarm;
`else
        assign o_alarm[c] = 1'b0;
`endif
    end

    logic [CNT_W-1:0] w_rd_data;

    always_comb begin
        w_rd_data = '0;
        if (int'(i_rd_ch) < NUM_CH) begin
            case (i_rd_sel)
                2'd0:    w_rd_data = w_evt_all[i_rd_ch];
                2'd1:    w_rd_data = w_hit_all[i_rd_ch];
                2'd2:    w_rd_data = w_miss_all[i_rd_ch];
                default: w_rd_data = CNT_W'(w_last_all[i_rd_ch]);
            endcase
        end
    end

    // Read port ignores i_clr so a clear-coincident read returns pre-clear data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_vld  <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_rd_vld <= i_rd_vld;
            if (i_rd_vld)
                o_rd_data <= w_rd_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
// ============================================================================
//  Module   : tb_perf_event_monitor
//  Purpose  : Directed self-checking bench for perf_event_monitor
//             (alarm expectations follow PERF_MON_ALARM_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_event_monitor;

    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] evt;
    logic [3:0] hit;
    logic       rd_vld;
    logic [1:0] rd_ch;
    logic [1:0] rd_sel;

    logic             a_rd_vld;
    logic [CNT_W-1:0] a_rd_data;
    logic [3:0]       a_win_done;
    logic [3:0]       a_alarm;

    logic             b_rd_vld;
    logic [CNT_W-1:0] b_rd_data;
    logic [2:0]       b_win_done;
    logic [2:0]       b_alarm;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_alarm;
    logic [9:0] pat;

`ifdef PERF_MON_ALARM_EN
    localparam bit c_alarm_en = 1'b1;
`else
    localparam bit c_alarm_en = 1'b0;
`endif

    perf_event_monitor #(.NUM_CH(4), .CNT_W(CNT_W), .WINDOW(64), .ALARM_THR(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .i_evt(evt), .i_hit(hit),
        .i_rd_vld(rd_vld), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel),
        .o_rd_vld(a_rd_vld), .o_rd_data(a_rd_data),
        .o_win_done(a_win_done), .o_alarm(a_alarm)
    );

    // Three-channel instance exposes an out-of-range channel index (3)
    perf_event_monitor #(.NUM_CH(3), .CNT_W(CNT_W), .WINDOW(64), .ALARM_THR(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .i_evt(evt[2:0]), .i_hit(hit[2:0]),
        .i_rd_vld(rd_vld), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel),
        .o_rd_vld(b_rd_vld), .o_rd_data(b_rd_data),
        .o_win_done(b_win_done), .o_alarm(b_alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [3:0] m, input logic [3:0] h);
        evt = m;
        hit = h;
        tick();
        evt = '0;
        hit = '0;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] exp,
                      input string tag);
        rd_vld = 1'b1;
        rd_ch  = ch;
        rd_sel = sel;
        tick();
        rd_vld = 1'b0;
        check({tag, "_vld"}, 32'(a_rd_vld), 32'd1);
        check(tag, 32'(a_rd_data), exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; evt = '0; hit = '0;
        rd_vld = 1'b0; rd_ch = '0; rd_sel = '0;
        exp_alarm = '0;
        repeat (3) tick();
        check("rst_rd_vld",   32'(a_rd_vld),   32'd0);
        check("rst_rd_data",  32'(a_rd_data),  32'd0);
        check("rst_win_done", 32'(a_win_done), 32'd0);
        check("rst_alarm",    32'(a_alarm),    32'd0);
        rst = 1'b0;

        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++)
                rd(2'(c), 2'(s), 32'd0, $sformatf("idle_c%0d_s%0d", c, s));
        check("idle_win_done", 32'(a_win_done), 32'd0);
        check("idle_alarm",    32'(a_alarm),    32'd0);

        // ch0: 10 events, pattern 1101101101 -> 7 hits, 3 misses
        pat = 10'b1101101101;
        for (int i = 9; i >= 0; i--)
            ev(4'b0001, {3'b000, pat[i]});
        rd(2'd0, 2'd0, 32'd10, "cnt_evt0");
        rd(2'd0, 2'd1, 32'd7,  "cnt_hit0");
        rd(2'd0, 2'd2, 32'd3,  "cnt_miss0");
        rd(2'd0, 2'd3, 32'd0,  "cnt_last0");
        rd(2'd1, 2'd0, 32'd0,  "cnt_evt1");
        rd(2'd3, 2'd0, 32'd0,  "cnt_evt3");

        en = 1'b0;
        for (int i = 0; i < 5; i++)
            ev(4'b1111, 4'b0000);
        en = 1'b1;
        rd(2'd0, 2'd0, 32'd10, "dis_evt0");
        rd(2'd0, 2'd2, 32'd3,  "dis_miss0");
        rd(2'd2, 2'd0, 32'd0,  "dis_evt2");

        // ch2: 64 events, last 20 are misses
        for (int i = 0; i < 64; i++) begin
            ev(4'b0100, (i < 44) ? 4'b0100 : 4'b0000);
            if (i == 62)
                check("win_early", 32'(a_win_done), 32'd0);
        end
        if (c_alarm_en)
            exp_alarm[2] = 1'b1;
        check("win_done2",  32'(a_win_done), 32'b0100);
        check("win_alarm2", 32'(a_alarm),    32'(exp_alarm));
        tick();
        check("win_pulse2", 32'(a_win_done), 32'd0);
        rd(2'd2, 2'd3, 32'd20, "win_last2");
        rd(2'd2, 2'd2, 32'd20, "win_miss2");
        ev(4'b0100, 4'b0100);
        rd(2'd2, 2'd3, 32'd20, "win_hold2");
        rd(2'd2, 2'd0, 32'd65, "win_evt2");

        // ch1 saturation
        for (int i = 0; i < 300; i++)
            ev(4'b0010, 4'b0010);
        rd(2'd1, 2'd0, 32'd255, "sat_evt1");
        rd(2'd1, 2'd1, 32'd255, "sat_hit1");
        rd(2'd1, 2'd2, 32'd0,   "sat_miss1");
        check("sat_alarm", 32'(a_alarm), 32'(exp_alarm));

        // ch3: 17-miss window then a clean window
        for (int i = 0; i < 64; i++)
            ev(4'b1000, (i < 17) ? 4'b0000 : 4'b1000);
        if (c_alarm_en)
            exp_alarm[3] = 1'b1;
        check("alm_done3",  32'(a_win_done), 32'b1000);
        check("alm_alarm3", 32'(a_alarm),    32'(exp_alarm));
        rd(2'd3, 2'd3, 32'd17, "alm_last3");
        for (int i = 0; i < 64; i++)
            ev(4'b1000, 4'b1000);
        check("clean_done3",  32'(a_win_done), 32'b1000);
        check("clean_alarm3", 32'(a_alarm),    32'(exp_alarm));
        rd(2'd3, 2'd3, 32'd0, "clean_last3");

        // Out-of-range channel on the three-channel instance
        rd(2'd3, 2'd0, 32'd128, "oor_a_evt3");
        check("oor_b_vld",  32'(b_rd_vld),  32'd1);
        check("oor_b_data", 32'(b_rd_data), 32'd0);

        // Read data holds while idle
        rd_ch = 2'd0;
        rd_sel = 2'd1;
        tick();
        check("hold_vld",  32'(a_rd_vld),  32'd0);
        check("hold_data", 32'(a_rd_data), 32'd128);

        // Clear, event and read in the same cycle
        clr = 1'b1; evt = 4'b0001; hit = 4'b0001;
        rd_vld = 1'b1; rd_ch = 2'd0; rd_sel = 2'd0;
        tick();
        clr = 1'b0; evt = '0; hit = '0; rd_vld = 1'b0;
        check("clr_rd_vld",  32'(a_rd_vld),  32'd1);
        check("clr_rd_data", 32'(a_rd_data), 32'd10);
        check("clr_alarm",   32'(a_alarm),   32'd0);
        rd(2'd0, 2'd0, 32'd0, "clr_evt0");
        rd(2'd2, 2'd3, 32'd0, "clr_last2");
        rd(2'd1, 2'd1, 32'd0, "clr_hit1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
